// File: rtl/pe_scatter_if.sv
// Stream bundle for pe_scatter: operand beats in, packed lane vectors out.
// Widths follow the N_PE / WID_PE_BITS macros unless overridden per instance.
`ifndef N_PE
`define N_PE 32
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

interface pe_scatter_if #(
    parameter int N_PE        = `N_PE,
    parameter int WID_PE_BITS = `WID_PE_BITS
);
    localparam int CW = $clog2(N_PE) + 1;

    logic                          in_valid;
    logic                          in_ready;
    logic signed [WID_PE_BITS-1:0] in_data;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [WID_PE_BITS*N_PE-1:0]   out_data_packed;
    logic [N_PE-1:0]               mac_enable;
    logic [CW-1:0]                 lane_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data_packed, mac_enable, lane_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data_packed, mac_enable, lane_count
    );
endinterface

// File: rtl/pe_scatter.sv
// Scatters a stream of signed operands into an N_PE-lane vector with a mac_enable mask.
// Define PE_SCATTER_PINGPONG_EN for two alternating banks (fill one while the other is held).
module pe_scatter #(
    parameter int N_PE        = `N_PE,
    parameter int WID_PE_BITS = `WID_PE_BITS
) (
    input  logic         clk,
    input  logic         rst,
    pe_scatter_if.slave  bus
);
    localparam int IW = $clog2(N_PE);
    localparam int CW = IW + 1;
`ifdef PE_SCATTER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                                   r_state     [NB];
    state_t                                   w_stateNext [NB];
    logic [NB-1:0][N_PE-1:0][WID_PE_BITS-1:0] r_lanes;
    logic [NB-1:0][N_PE-1:0]                  r_mask;
    logic [NB-1:0][CW-1:0]                    r_count;
    logic [IW-1:0]                            r_idx;
    logic                                     w_wb;
    logic                                     w_rb;
    logic                                     w_accept;
    logic                                     w_close;
    logic                                     w_xfer;

`ifdef PE_SCATTER_PINGPONG_EN
    logic r_wb;
    logic r_rb;

    // Fill and drain pointers alternate, so vectors leave in the order they closed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb <= 1'b0;
            r_rb <= 1'b0;
        end else begin
            if (w_accept && w_close) r_wb <= ~r_wb;
            if (w_xfer)              r_rb <= ~r_rb;
        end
    end

    assign w_wb = r_wb;
    assign w_rb = r_rb;
`else
    assign w_wb = 1'b0;
    assign w_rb = 1'b0;
`endif

    assign bus.in_ready  = rst && (r_state[w_wb] == FILL);
    assign bus.out_valid = (r_state[w_rb] == HOLD);

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_close  = bus.in_last || (r_idx == IW'(N_PE - 1));
    assign w_xfer   = bus.out_valid && bus.out_ready;

    assign bus.out_data_packed = bus.out_valid ? r_lanes[w_rb] : '0;
    assign bus.mac_enable      = bus.out_valid ? r_mask[w_rb]  : '0;
    assign bus.lane_count      = bus.out_valid ? r_count[w_rb] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++) r_state[b] <= FILL;
        end else begin
            for (int b = 0; b < NB; b++) r_state[b] <= w_stateNext[b];
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_stateNext[b] = r_state[b];
            case (r_state[b])
                FILL: if (w_accept && w_close && (w_wb == 1'(b))) w_stateNext[b] = HOLD;
                HOLD: if (w_xfer && (w_rb == 1'(b)))              w_stateNext[b] = FILL;
                default: w_stateNext[b] = FILL;
            endcase
        end
    end

    // Transfer and accept never target the same bank, so both updates can land on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lanes <= '0;
            r_mask  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            if (w_xfer) begin
                r_lanes[w_rb] <= '0;
                r_mask[w_rb]  <= '0;
                r_count[w_rb] <= '0;
            end
            if (w_accept) begin
                r_lanes[w_wb][r_idx] <= bus.in_data;
                r_mask[w_wb][r_idx]  <= 1'b1;
                if (w_close) begin
                    r_count[w_wb] <= CW'(r_idx) + CW'(1);
                    r_idx         <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end
endmodule
